// File: rtl/pipelined_segmented_fan_if.sv
// Handshake bundle for pipelined_segmented_fan.
// Input side: in_valid/in_ready with the leaf operands, vec_ids and lane_en.
// Output side: out_valid/out_ready with the N-1 node sums, node vec_ids and
// node valid flags (node index = (N - (N>>l)) + i for node i of level l+1).
// Modports: slave is the reduction block, master is whoever drives it.
interface pipelined_segmented_fan_if #(
  parameter int N = 16,
  parameter int W = 8,
  parameter int V = 3
);
  localparam int S = W + $clog2(N);

  logic                    in_valid;
  logic                    in_ready;
  logic [N-1:0][W-1:0]     operands;
  logic [N-1:0][V-1:0]     vec_ids;
  logic [N-1:0]            lane_en;
  logic                    out_valid;
  logic                    out_ready;
  logic [N-2:0][S-1:0]     id_sums;
  logic [N-2:0][V-1:0]     id_vecs;
  logic [N-2:0]            id_valids;

  modport master (
    output in_valid, operands, vec_ids, lane_en, out_ready,
    input  in_ready, out_valid, id_sums, id_vecs, id_valids
  );

  modport slave (
    input  in_valid, operands, vec_ids, lane_en, out_ready,
    output in_ready, out_valid, id_sums, id_vecs, id_valids
  );
endinterface

// File: rtl/pipelined_segmented_fan.sv
// Pipelined, vector-ID-aware forwarding adder network.
// Reduces N operands pairwise in a log2(N)-level binary tree; every one of the
// N-1 tree nodes reports its sum, the vec_id of its lowest-index enabled leaf
// and a flag telling whether all enabled leaves under it share that vec_id.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (flushes every in-flight beat)
//   bus  - slave side of pipelined_segmented_fan_if (valid/ready in and out)
// One pipeline stage per tree level; the whole pipe stalls together while the
// output holds a beat that downstream does not take.
module pipelined_segmented_fan #(
  parameter int N      = 16,
  parameter int W      = 8,
  parameter int V      = 3,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_segmented_fan_if.slave bus
);

  localparam int L = $clog2(N);
  localparam int S = W + L;

  typedef struct packed {
    logic [S-1:0] sum;
    logic [V-1:0] id;
    logic         present;  // at least one enabled leaf below
    logic         homog;    // enabled leaves below agree on id
  } node_t;

  // Sign- or zero-extend a leaf operand to the node sum width.
  function automatic logic [S-1:0] extend(input logic [W-1:0] op);
    logic fill;
    fill = (SIGNED != 32'sd0) ? op[W-1] : 1'b0;
    return {{L{fill}}, op};
  endfunction

  // Combine two sibling nodes; a is the lower-index child. A node with no
  // enabled leaf reports id 0 so id_vecs reads 0 for empty subtrees.
  function automatic node_t merge_nodes(input node_t a, input node_t b);
    node_t m;
    m.sum     = a.sum + b.sum;
    m.present = a.present | b.present;
    m.id      = a.present ? a.id : (b.present ? b.id : {V{1'b0}});
    m.homog   = (a.homog | ~a.present) & (b.homog | ~b.present)
              & ~(a.present & b.present & (a.id != b.id));
    return m;
  endfunction

  // lvl_in_s[k] holds the children feeding stage k (leaves for stage 0).
  // next_s[k] / data_r[k] use the global node numbering; stage k fills the
  // nodes of levels 1..k+1 and leaves the rest at zero.
  node_t [N-1:0] lvl_in_s [L];
  node_t [N-2:0] next_s   [L];
  node_t [N-2:0] data_r   [L];
  logic  [L-1:0] valid_r;
  logic          advance_s;

  assign advance_s    = ~valid_r[L-1] | bus.out_ready;
  assign bus.in_ready = advance_s;
  assign bus.out_valid = valid_r[L-1];

  // Leaf preparation, tree-level merge per stage and carry of lower levels.
  always_comb begin
    for (int k = 0; k < L; k++) begin
      lvl_in_s[k] = '0;
      next_s[k]   = '0;
    end
    for (int j = 0; j < N; j++) begin
      lvl_in_s[0][j].sum     = bus.lane_en[j] ? extend(bus.operands[j]) : {S{1'b0}};
      lvl_in_s[0][j].id      = bus.vec_ids[j];
      lvl_in_s[0][j].present = bus.lane_en[j];
      lvl_in_s[0][j].homog   = 1'b1;
    end
    for (int k = 1; k < L; k++) begin
      // Children of stage k are the level-k nodes held by stage k-1.
      for (int i = 0; i < (N >> k); i++) begin
        lvl_in_s[k][i] = data_r[k-1][(N - (N >> (k - 1))) + i];
      end
      // Lower levels ride along unchanged so the whole beat exits together.
      for (int j = 0; j < N - (N >> k); j++) begin
        next_s[k][j] = data_r[k-1][j];
      end
    end
    for (int k = 0; k < L; k++) begin
      for (int i = 0; i < (N >> (k + 1)); i++) begin
        next_s[k][(N - (N >> k)) + i] = merge_nodes(lvl_in_s[k][2*i], lvl_in_s[k][2*i+1]);
      end
    end
  end

  // Pipeline registers: advance together, bubbles carry zeroed data so the
  // outputs read 0 whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int k = 0; k < L; k++) begin
        data_r[k] <= '0;
      end
    end else if (advance_s) begin
      valid_r   <= {valid_r[L-2:0], bus.in_valid};
      data_r[0] <= bus.in_valid ? next_s[0] : '0;
      for (int k = 1; k < L; k++) begin
        data_r[k] <= valid_r[k-1] ? next_s[k] : '0;
      end
    end
  end

  // Unpack the last stage onto the output bus.
  always_comb begin
    bus.id_sums   = '0;
    bus.id_vecs   = '0;
    bus.id_valids = '0;
    for (int j = 0; j < N - 1; j++) begin
      bus.id_sums[j]   = data_r[L-1][j].sum;
      bus.id_vecs[j]   = data_r[L-1][j].id;
      bus.id_valids[j] = data_r[L-1][j].homog & data_r[L-1][j].present;
    end
  end

endmodule

// File: tb/tb_pipelined_segmented_fan.sv
// Self-checking bench for pipelined_segmented_fan (N=8, W=8, V=3).
// Drives an unsigned and a signed build with identical stimulus; expected
// results come from a constant table and a per-node subtree model.
module tb_pipelined_segmented_fan;
  localparam int N = 8;
  localparam int W = 8;
  localparam int V = 3;
  localparam int S = 11;

  typedef logic [N-1:0][W-1:0] ops_t;
  typedef logic [N-1:0][V-1:0] ids_t;
  typedef struct packed {
    logic [N-2:0][S-1:0] sums;
    logic [N-2:0][V-1:0] vecs;
    logic [N-2:0]        valids;
  } exp_t;
  typedef struct { exp_t u; exp_t s; } beat_t;
  typedef struct { ops_t ops; ids_t ids; logic [N-1:0] en; exp_t u; exp_t s; } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  ops_t operands;
  ids_t vec_ids;
  logic [N-1:0] lane_en;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  beat_t sb[$];
  logic hold_pending = 1'b0;
  exp_t hold_u, hold_s;
  vec_t tbl[5];

  always #5 clk = ~clk;

  pipelined_segmented_fan_if #(.N(N), .W(W), .V(V)) bus_u();
  pipelined_segmented_fan_if #(.N(N), .W(W), .V(V)) bus_s();

  assign bus_u.in_valid = in_valid;
  assign bus_u.operands = operands;
  assign bus_u.vec_ids = vec_ids;
  assign bus_u.lane_en = lane_en;
  assign bus_u.out_ready = out_ready;
  assign bus_s.in_valid = in_valid;
  assign bus_s.operands = operands;
  assign bus_s.vec_ids = vec_ids;
  assign bus_s.lane_en = lane_en;
  assign bus_s.out_ready = out_ready;

  pipelined_segmented_fan #(.N(N), .W(W), .V(V), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .bus(bus_u));
  pipelined_segmented_fan #(.N(N), .W(W), .V(V), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .bus(bus_s));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [N-2:0][S-1:0] sums, input logic [N-2:0][V-1:0] vecs,
                              input logic [N-2:0] valids);
    exp_t e;
    e.sums = sums;
    e.vecs = vecs;
    e.valids = valids;
    return e;
  endfunction

  // Each node summarises the contiguous leaf range it covers.
  function automatic exp_t model(input ops_t ops, input ids_t ids, input logic [N-1:0] en, input bit sgn);
    exp_t e;
    int idx, acc;
    bit any, same;
    logic [V-1:0] first;
    e = '0;
    idx = 0;
    for (int lvl = 1; lvl <= $clog2(N); lvl++) begin
      for (int i = 0; i < (N >> lvl); i++) begin
        acc = 0; any = 1'b0; same = 1'b1; first = '0;
        for (int j = i << lvl; j < ((i + 1) << lvl); j++) begin
          if (en[j]) begin
            acc += sgn ? int'($signed(ops[j])) : int'(ops[j]);
            if (!any) begin
              first = ids[j];
              any = 1'b1;
            end else if (ids[j] != first) begin
              same = 1'b0;
            end
          end
        end
        e.sums[idx] = acc[S-1:0];
        e.vecs[idx] = first;
        e.valids[idx] = any && same;
        idx++;
      end
    end
    return e;
  endfunction

  function automatic exp_t out_u();
    return {bus_u.id_sums, bus_u.id_vecs, bus_u.id_valids};
  endfunction

  function automatic exp_t out_s();
    return {bus_s.id_sums, bus_s.id_vecs, bus_s.id_valids};
  endfunction

  // Called mid-cycle: inputs and registered outputs are both stable.
  task automatic monitor();
    exp_t au, as_;
    beat_t b;
    au = out_u();
    as_ = out_s();
    chk("in_ready_rule", bus_u.in_ready, !bus_u.out_valid || out_ready);
    chk("valid_agree", bus_s.out_valid, bus_u.out_valid);
    if (hold_pending) begin
      chk("stall_valid", bus_u.out_valid, 1'b1);
      chk("stall_hold_u", au, hold_u);
      chk("stall_hold_s", as_, hold_s);
    end
    if (!bus_u.out_valid) begin
      chk("idle_zero_u", au, '0);
      chk("idle_zero_s", as_, '0);
    end else if (out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=no_beat", au);
      end else begin
        b = sb.pop_front();
        chk("beat_u", au, b.u);
        chk("beat_s", as_, b.s);
        pops++;
      end
    end
    hold_pending = bus_u.out_valid && !out_ready;
    hold_u = au;
    hold_s = as_;
    if (in_valid && bus_u.in_ready) begin
      b.u = model(operands, vec_ids, lane_en, 1'b0);
      b.s = model(operands, vec_ids, lane_en, 1'b1);
      sb.push_back(b);
    end
  endtask

  task automatic step(input logic iv, input logic ordy);
    in_valid = iv;
    out_ready = ordy;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    logic [V-1:0] common;
    common = V'($urandom_range(0, 7));
    for (int j = 0; j < N; j++) begin
      operands[j] = W'($urandom);
      vec_ids[j] = ($urandom_range(0, 1) == 0) ? common : V'($urandom_range(0, 1));
    end
    case ($urandom_range(0, 3))
      0: lane_en = 8'hFF;
      1: lane_en = 8'h0F;
      default: lane_en = 8'($urandom);
    endcase
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, bus_u.out_valid, 1'b0);
    chk({tag, "_out_valid_s"}, bus_s.out_valid, 1'b0);
    chk({tag, "_outs_u"}, out_u(), '0);
    chk({tag, "_outs_s"}, out_s(), '0);
    chk({tag, "_in_ready"}, bus_u.in_ready, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, acc, c, p0;
    exp_t ident;

    tbl[0].ops = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    tbl[0].ids = {8{3'd2}};
    tbl[0].en = 8'hFF;
    tbl[0].u = mk({11'd36, 11'd26, 11'd10, 11'd15, 11'd11, 11'd7, 11'd3}, {7{3'd2}}, 7'h7F);
    tbl[0].s = tbl[0].u;

    tbl[1].ops = {8{8'd5}};
    tbl[1].ids = {3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    tbl[1].en = 8'hFF;
    tbl[1].u = mk({11'd40, 11'd20, 11'd20, 11'd10, 11'd10, 11'd10, 11'd10},
                  {3'd0, 3'd1, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0}, 7'h3F);
    tbl[1].s = tbl[1].u;

    tbl[2].ops = {8{8'd3}};
    tbl[2].ids = {3'd7, 3'd7, 3'd7, 3'd7, 3'd1, 3'd1, 3'd1, 3'd1};
    tbl[2].en = 8'h0F;
    tbl[2].u = mk({11'd12, 11'd0, 11'd12, 11'd0, 11'd0, 11'd6, 11'd6},
                  {3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1}, 7'h53);
    tbl[2].s = tbl[2].u;

    tbl[3].ops = {8{8'h80}};
    tbl[3].ids = {8{3'd3}};
    tbl[3].en = 8'hFF;
    tbl[3].u = mk({11'h400, 11'h200, 11'h200, 11'h100, 11'h100, 11'h100, 11'h100}, {7{3'd3}}, 7'h7F);
    tbl[3].s = mk({11'h400, 11'h600, 11'h600, 11'h700, 11'h700, 11'h700, 11'h700}, {7{3'd3}}, 7'h7F);

    tbl[4].ops = {8{8'hFF}};
    tbl[4].ids = {3'd6, 3'd5, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0};
    tbl[4].en = 8'hF0;
    tbl[4].u = mk({11'h3FC, 11'h3FC, 11'h000, 11'h1FE, 11'h1FE, 11'h000, 11'h000},
                  {3'd5, 3'd5, 3'd0, 3'd5, 3'd5, 3'd0, 3'd0}, 7'h04);
    tbl[4].s = mk({11'h7FC, 11'h7FC, 11'h000, 11'h7FE, 11'h7FE, 11'h000, 11'h000},
                  {3'd5, 3'd5, 3'd0, 3'd5, 3'd5, 3'd0, 3'd0}, 7'h04);

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    operands = '0;
    vec_ids = '0;
    lane_en = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Directed table: three register stages, the accepting edge loads stage 0.
    for (int t = 0; t < 5; t++) begin
      operands = tbl[t].ops;
      vec_ids = tbl[t].ids;
      lane_en = tbl[t].en;
      step(1'b1, 1'b1);
      waited = 0;
      while (!bus_u.out_valid && waited < 8) begin
        step(1'b0, 1'b1);
        waited++;
      end
      chk($sformatf("latency_%0d", t), waited, 2);
      chk($sformatf("table_u_%0d", t), out_u(), tbl[t].u);
      chk($sformatf("table_s_%0d", t), out_s(), tbl[t].s);
      ident = model(tbl[t].ops, tbl[t].ids, tbl[t].en, 1'b0);
      step(1'b0, 1'b1);
    end

    // Ten back-to-back beats with out_ready 1,0,0,1,0,0,...
    p0 = pops;
    acc = 0;
    c = 0;
    while (c < 200 && (acc < 10 || sb.size() != 0 || bus_u.out_valid)) begin
      if (acc < 10) begin
        rand_beat();
        if (!bus_u.out_valid || (c % 3 == 0)) acc++;
        step(1'b1, (c % 3 == 0));
      end else begin
        step(1'b0, (c % 3 == 0));
      end
      c++;
    end
    chk("b2b_emitted", pops - p0, 10);

    // Reset with three beats in flight.
    for (int b = 0; b < 3; b++) begin
      rand_beat();
      step(1'b1, 1'b1);
    end
    chk("inflight_valid", bus_u.out_valid, 1'b1);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    hold_pending = 1'b0;
    check_reset_state("midrst");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      chk($sformatf("no_stale_%0d", i), bus_u.out_valid, 1'b0);
    end

    // Random traffic against the subtree model.
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
    end
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
